bus_copy_dma: RTL



---
 rtl/bus_copy_dma_pkg.sv | 6 +
 rtl/bus_timeout_cnt.sv | 19 +
 rtl/bus_copy_dma.sv | 91 +++++++++
 3 files changed

// File: rtl/bus_copy_dma_pkg.sv
// bus_copy_dma_pkg: shared FSM states and bus constants for the copy DMA
package bus_copy_dma_pkg;
  typedef enum logic [2:0] {IDLE, REQ, RD, RDLAT, WR, FIN} state_e;
  localparam logic [3:0] SEL_WORD = 4'hF;
  localparam logic [7:0] BANK_RAM = 8'h00;
endpackage

// File: rtl/bus_timeout_cnt.sv
// bus_timeout_cnt: stb/ack watchdog; expire_o on the TIMEOUT-th unacked strobe cycle (clk, rst_n_i, stb_i, ack_i -> expire_o)
module bus_timeout_cnt #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n_i,
  input  logic stb_i,
  input  logic ack_i,
  output logic expire_o
);
  localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  // restarts whenever the strobe is low or a transfer completes
  assign cnt_d = (stb_i && !ack_i) ? cnt_q + 1'b1 : '0;
  assign expire_o = (TIMEOUT != 0) && stb_i && !ack_i && (cnt_q == W'(TIMEOUT - 1));
  always_ff @(posedge clk or negedge rst_n_i)
    if (!rst_n_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/bus_copy_dma.sv
// bus_copy_dma: word-copy DMA initiator (start/src/dst/len in, busy/done/err out, req/gnt + stb/ack bus master)
module bus_copy_dma
  import bus_copy_dma_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [31:0]      src_i,
  input  logic [31:0]      dst_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             bus_req_o,
  input  logic             bus_gnt_i,
  output logic [31:0]      adr_o,
  output logic [31:0]      dat_o,
  input  logic [31:0]      dat_i,
  output logic [3:0]       sel_o,
  output logic             we_o,
  output logic             stb_o,
  input  logic             ack_i
);
  state_e state_q, state_d;
  logic [31:0] src_q, src_d, dst_q, dst_d, buf_q, buf_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d, expire;
  bus_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk(clk), .rst_n_i(rst_n_i), .stb_i(stb_o), .ack_i(ack_i), .expire_o(expire)
  );
  // outputs decode straight from state so reset drops the bus immediately
  assign bus_req_o = state_q inside {REQ, RD, RDLAT, WR};
  assign busy_o    = bus_req_o;
  assign done_o    = state_q == FIN;
  assign err_o     = err_q;
  assign stb_o     = state_q == RD || state_q == WR;
  assign we_o      = state_q == WR;
  assign sel_o     = stb_o ? SEL_WORD : 4'h0;
  assign adr_o     = state_q == RD ? src_q : state_q == WR ? dst_q : '0;
  assign dat_o     = we_o ? buf_q : '0;
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    err_d   = err_q | expire;
    case (state_q)
      IDLE: if (start_i) begin
        src_d   = src_i & ~32'h3;
        dst_d   = dst_i & ~32'h3;
        cnt_d   = len_i;
        err_d   = 1'b0;
        state_d = len_i == '0 ? FIN : REQ;
      end
      REQ:   state_d = bus_gnt_i ? RD : REQ;
      RD:    state_d = expire ? FIN : ack_i ? RDLAT : RD;
      RDLAT: begin
        buf_d   = dat_i;
        state_d = WR;
      end
      WR: if (ack_i) begin
        src_d   = src_q + 32'd4;
        dst_d   = dst_q + 32'd4;
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == LEN_W'(1) ? FIN : RD;
      end else if (expire) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
endmodule
